fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of decode and immediate generation. Holds the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and presents each fetched instruction with its PC to decode through a one-entry valid/ready output register. Branch and jump redirects from execute flush the output and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0)

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IMemReq  out  1  fetch request valid
- IMemAddr  out  32  fetch address, word aligned, bits [1:0] always 0
- IMemGnt  in  1  memory accepts the request this cycle (meaningful only while IMemReq=1)
- IMemRvalid  in  1  read data valid
- IMemRdata  in  32  instruction word
- Redirect  in  1  taken branch/jump from execute
- RedirectPC  in  32  new fetch address; bits [1:0] ignored
- InstrValid  out  1  output register holds a valid instruction
- InstrReady  in  1  decode accepts the instruction this cycle
- Instr  out  32  instruction word to decode / immediate generator
- PC  out  32  address of Instr
- PC4  out  32  PC + 4, modulo 2^32

## Operation
- Internal state: FetchPC (32), FSM {REQ, WAIT}, Drop flag, output register {OutValid, Instr, PC}.
- At most one outstanding memory request.
- REQ: IMemReq = !rst && !Redirect && (!OutValid || InstrReady); IMemAddr = {FetchPC[31:2], 2'b00}. IMemReq && IMemGnt -> WAIT. IMemRvalid in REQ is ignored.
- WAIT: IMemReq = 0. On IMemRvalid:
  - Drop = 0: load Instr = IMemRdata, PC = FetchPC, OutValid = 1; FetchPC += 4 (wraps 0xFFFF_FFFC -> 0x0000_0000); -> REQ.
  - Drop = 1: discard data, clear Drop, FetchPC unchanged; -> REQ.
- Output handshake: InstrValid && InstrReady consumes the entry; OutValid clears unless refilled in the same cycle.
- Redirect (highest priority, any state):
  - FetchPC <= {RedirectPC[31:2], 2'b00}; OutValid <= 0, even if InstrReady=1 that cycle (entry is flushed, not consumed).
  - REQ: stays REQ; no request that cycle.
  - WAIT without IMemRvalid: Drop <= 1, stay WAIT.
  - WAIT with IMemRvalid: data discarded, Drop <= 0, -> REQ.
  - Back-to-back redirects: the last one wins; Drop stays 1.
- Instr, PC and PC4 are stable while InstrValid=1 and InstrReady=0.

## Timing
- Reset values: FetchPC = RESET_PC, state = REQ, Drop = 0, InstrValid = 0, Instr = 32'h0000_0013 (NOP), PC = 0, PC4 = 4, IMemReq = 0, IMemAddr = RESET_PC.
- rst asserted mid-transaction returns to the reset state next cycle. Instruction memory shares rst, so no stale response is expected; any IMemRvalid that arrives is ignored, since the FSM is in REQ.
- IMemRvalid arrives no earlier than the cycle after the grant.
- Best case, zero-wait grant and 1-cycle response:
  - request in cycle n;
  - IMemRvalid in cycle n+1;
  - InstrValid = 1 from cycle n+2;
  - next request in cycle n+2 if InstrReady = 1.
- Sustained throughput: one instruction every 2 cycles.
- Redirect in cycle n: the first request to the new target is issued in cycle n+1 from REQ, or in the cycle after the dropped response from WAIT.
- PC4 is combinational from the PC register. IMemReq depends combinationally on InstrReady, Redirect and rst.

## Test plan
- Reset release, RESET_PC = 0, memory with 1-cycle grant and 1-cycle response, InstrReady = 1. Required response:
  - IMemAddr sequence 0x0, 0x4, 0x8;
  - Instr/PC pairs delivered in order;
  - PC4 = PC + 4;
  - InstrValid low during reset with Instr = 0x13.
- Backpressure: hold InstrReady = 0 for 5 cycles with an instruction at PC = 0x4. Required response:
  - Instr, PC and InstrValid remain stable;
  - IMemReq stays 0;
  - the request for 0x8 is issued in the cycle InstrReady rises.
- Redirect during WAIT: Redirect = 1 with RedirectPC = 0x103 while the response for 0x8 is pending. Required response:
  - the 0x8 data is discarded and never presented;
  - the next IMemAddr is 0x100;
  - the first valid output is PC = 0x100.
- Redirect in the same cycle as IMemRvalid, and separately in the same cycle as InstrValid && InstrReady. Required response in both cases:
  - the response or entry is dropped;
  - InstrValid = 0 next cycle;
  - the fetch resumes at the target.
- Wrap-around: RedirectPC = 0xFFFF_FFFC. Required response:
  - the instruction is delivered with PC = 0xFFFF_FFFC and PC4 = 0;
  - the next IMemAddr is 0x0000_0000.
- Grant delayed 3 cycles and response delayed 4 cycles, with rst asserted for one cycle while in WAIT. Required response:
  - IMemReq is held until the grant;
  - after rst, the state matches the reset values;
  - the late IMemRvalid is ignored;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: holds the fetch PC, issues one word read at a time to
// instruction memory, and hands each instruction to decode via a one-entry output register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRvalid,
  input  logic [31:0] IMemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC4
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
  } out_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic        drop;
  out_t        out_q;
  logic        rsp, load;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  always_comb begin
    state_nxt = state;
    IMemReq   = 1'b0;
    rsp       = (state == S_WAIT) && IMemRvalid;
    load      = rsp && !drop && !Redirect;
    case (state)
      S_REQ: begin
        // Only request when the output slot is free or being drained this cycle.
        IMemReq = !rst && !Redirect && (!out_q.vld || InstrReady);
        if (IMemReq && IMemGnt) state_nxt = S_WAIT;
      end
      S_WAIT: if (IMemRvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      drop     <= 1'b0;
      out_q    <= '{vld: 1'b0, instr: NOP, pc: 32'h0};
    end else begin
      if (Redirect) begin
        fetch_pc <= {RedirectPC[31:2], 2'b00};
        // A response still in flight belongs to the old stream; remember to discard it.
        drop     <= (state == S_WAIT) && !IMemRvalid;
      end else if (rsp) begin
        drop <= 1'b0;
        if (!drop) fetch_pc <= fetch_pc + 32'd4;
      end

      if (Redirect)                  out_q.vld <= 1'b0;
      else if (load)                 out_q     <= '{vld: 1'b1, instr: IMemRdata, pc: fetch_pc};
      else if (out_q.vld && InstrReady) out_q.vld <= 1'b0;
    end
  end

  assign IMemAddr   = {fetch_pc[31:2], 2'b00};
  assign InstrValid = out_q.vld;
  assign Instr      = out_q.instr;
  assign PC         = out_q.pc;
  assign PC4        = out_q.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory with programmable grant
// and response delays; memory word at address a is a ^ 32'hC0DE_0000.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt = 1'b0;
  logic        IMemRvalid = 1'b0;
  logic [31:0] IMemRdata = 32'h0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic [31:0] Instr, PC, PC4;

  int errors = 0;
  int checks = 0;

  // memory model state
  int          gnt_dly = 0;
  int          rsp_dly = 1;
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  bit          busy = 0;
  logic [31:0] pend = 32'h0;
  logic [31:0] addrs[$];
  bit          seen8 = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRvalid(IMemRvalid), .IMemRdata(IMemRdata),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .PC(PC), .PC4(PC4)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the memory model from what happened before it.
  task automatic clk_next;
    bit fire, rv, rq;
    logic [31:0] a;
    fire = IMemReq && IMemGnt;
    rq   = IMemReq;
    rv   = IMemRvalid;
    a    = IMemAddr;
    if (InstrValid && PC == 32'h8) seen8 = 1;
    @(posedge clk); #1;
    if (rv) busy = 0;
    if (fire) begin
      busy = 1; rsp_cnt = 1; pend = a; addrs.push_back(a);
    end else if (busy) rsp_cnt++;
    req_cnt = (rq && !fire) ? req_cnt + 1 : 0;
  endtask

  // Drive memory responses for the current cycle, after the test has set its inputs.
  task automatic settle;
    IMemRvalid = busy && (rsp_cnt == rsp_dly);
    IMemRdata  = IMemRvalid ? (pend ^ 32'hC0DE_0000) : 32'hDEAD_BEEF;
    #1;
    IMemGnt = IMemReq && (req_cnt >= gnt_dly);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      clk_next; settle;
      if (InstrValid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    clk_next; settle;
    clk_next; settle;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
    checks++; if (Instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", Instr); end
    checks++; if (PC !== 32'h0 || PC4 !== 32'h4) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/4", PC, PC4); end
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", IMemReq); end
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", IMemAddr); end
  endtask

  task automatic test_basic;
    clk_next; rst = 0; settle;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL basic_req0: got %b/%h want 1/0", IMemReq, IMemAddr); end
    clk_next; settle;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL basic_wait_noreq: got %b want 0", IMemReq); end
    clk_next; settle;
    checks++; if (InstrValid !== 1'b1 || Instr !== 32'hC0DE_0000 || PC !== 32'h0 || PC4 !== 32'h4)
      begin errors++; $display("FAIL basic_out0: got v%b %h pc %h pc4 %h want v1 c0de0000 pc 0 pc4 4", InstrValid, Instr, PC, PC4); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin errors++; $display("FAIL basic_req4: got %b/%h want 1/4", IMemReq, IMemAddr); end
    clk_next; settle;
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", InstrValid); end
  endtask

  task automatic test_backpressure;
    clk_next; InstrReady = 0; settle;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin clk_next; settle; end
      checks++;
      if ({InstrValid, PC, Instr, PC4, IMemReq} !== {1'b1, 32'h4, 32'hC0DE_0004, 32'h8, 1'b0})
        begin errors++; $display("FAIL bp_hold%0d: got v%b pc %h %h pc4 %h req %b want v1 pc 4 c0de0004 pc4 8 req 0", i, InstrValid, PC, Instr, PC4, IMemReq); end
    end
    clk_next; InstrReady = 1; settle;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin errors++; $display("FAIL bp_release: got %b/%h want 1/8", IMemReq, IMemAddr); end
    rsp_dly = 2;
  endtask

  task automatic test_redirect_wait;
    bit ok;
    clk_next; Redirect = 1; RedirectPC = 32'h103; settle;
    checks++;
    if (addrs.size() != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8)
      begin errors++; $display("FAIL addr_seq: got %0d entries, want 0,4,8", addrs.size()); end
    checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rw_redir: got req %b v %b want 0 0", IMemReq, InstrValid); end
    clk_next; Redirect = 0; settle;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rw_dropcycle_req: got %b want 0", IMemReq); end
    rsp_dly = 1;
    clk_next; settle;
    checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h100)
      begin errors++; $display("FAIL rw_target: got v%b req %b addr %h want v0 req 1 addr 100", InstrValid, IMemReq, IMemAddr); end
    wait_valid(ok);
    checks++; if (!ok || PC !== 32'h100 || Instr !== 32'hC0DE_0100)
      begin errors++; $display("FAIL rw_first_out: got ok %b pc %h %h want pc 100 c0de0100", ok, PC, Instr); end
    checks++; if (seen8 !== 1'b0) begin errors++; $display("FAIL rw_discard: got seen8 %b want 0", seen8); end
  endtask

  task automatic test_redirect_rvalid;
    bit ok;
    clk_next; Redirect = 1; RedirectPC = 32'h200; settle;
    checks++; if (IMemRvalid !== 1'b1 || IMemReq !== 1'b0 || InstrValid !== 1'b0)
      begin errors++; $display("FAIL rr_setup: got rv %b req %b v %b want 1 0 0", IMemRvalid, IMemReq, InstrValid); end
    clk_next; Redirect = 0; settle;
    checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h200)
      begin errors++; $display("FAIL rr_next: got v%b req %b addr %h want v0 req 1 addr 200", InstrValid, IMemReq, IMemAddr); end
    wait_valid(ok);
    checks++; if (!ok || PC !== 32'h200 || Instr !== 32'hC0DE_0200)
      begin errors++; $display("FAIL rr_out: got ok %b pc %h %h want pc 200 c0de0200", ok, PC, Instr); end
  endtask

  task automatic test_redirect_handshake;
    bit ok;
    Redirect = 1; RedirectPC = 32'h300; settle;
    checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b1) begin errors++; $display("FAIL rh_setup: got req %b v %b want 0 1", IMemReq, InstrValid); end
    clk_next; Redirect = 0; settle;
    checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h300)
      begin errors++; $display("FAIL rh_flush: got v%b req %b addr %h want v0 req 1 addr 300", InstrValid, IMemReq, IMemAddr); end
    wait_valid(ok);
    checks++; if (!ok || PC !== 32'h300 || Instr !== 32'hC0DE_0300)
      begin errors++; $display("FAIL rh_out: got ok %b pc %h %h want pc 300 c0de0300", ok, PC, Instr); end
  endtask

  task automatic test_wrap;
    bit ok;
    clk_next; Redirect = 1; RedirectPC = 32'hFFFF_FFFC; settle;
    clk_next; Redirect = 0; settle;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", IMemReq, IMemAddr); end
    wait_valid(ok);
    checks++; if (!ok || PC !== 32'hFFFF_FFFC || PC4 !== 32'h0 || Instr !== 32'h3F21_FFFC)
      begin errors++; $display("FAIL wrap_out: got ok %b pc %h pc4 %h %h want pc fffffffc pc4 0 3f21fffc", ok, PC, PC4, Instr); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      begin errors++; $display("FAIL wrap_next: got %b/%h want 1/0", IMemReq, IMemAddr); end
  endtask

  task automatic test_delay_reset;
    bit ok;
    clk_next; settle;
    gnt_dly = 3; rsp_dly = 4;
    for (int i = 0; i < 4; i++) begin
      clk_next; settle;
      checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4 || IMemGnt !== (i == 3))
        begin errors++; $display("FAIL dly_hold%0d: got req %b addr %h gnt %b want 1 4 %0d", i, IMemReq, IMemAddr, IMemGnt, (i == 3)); end
    end
    clk_next; settle;
    clk_next; rst = 1; settle;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL dly_rst_req: got %b want 0", IMemReq); end
    clk_next; rst = 0; settle;
    checks++; if ({InstrValid, Instr, PC, PC4, IMemReq, IMemAddr} !== {1'b0, 32'h13, 32'h0, 32'h4, 1'b1, 32'h0})
      begin errors++; $display("FAIL dly_after_rst: got v%b %h pc %h pc4 %h req %b addr %h want v0 13 0 4 1 0", InstrValid, Instr, PC, PC4, IMemReq, IMemAddr); end
    clk_next; settle;
    checks++; if (IMemRvalid !== 1'b1 || IMemReq !== 1'b1) begin errors++; $display("FAIL dly_stale_setup: got rv %b req %b want 1 1", IMemRvalid, IMemReq); end
    clk_next; settle;
    checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      begin errors++; $display("FAIL dly_stale_ignored: got v%b req %b addr %h want v0 req 1 addr 0", InstrValid, IMemReq, IMemAddr); end
    wait_valid(ok);
    checks++; if (!ok || PC !== 32'h0 || Instr !== 32'hC0DE_0000)
      begin errors++; $display("FAIL dly_restart: got ok %b pc %h %h want pc 0 c0de0000", ok, PC, Instr); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_redirect_wait;
    test_redirect_rvalid;
    test_redirect_handshake;
    test_wrap;
    test_delay_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
